// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares the single-port video memory between VGA scanout and two pixel writers
// Ports:
//    clk, resetn            clock, asynchronous active-low reset
//    vga_rd_req/addr        scanout read request and pixel address
//    vga_rd_data/valid      pixel returned two cycles after the request
//    vga_underrun           returned pixel is stale because its read was preempted
//    wN_valid/ready/addr/data  writer N (0 = keyboard drawer, 1 = UART loader) handshake
//    mem_en/we/addr/wdata   access to the storage array, mem_rdata returns one cycle after a read
//    preempt_cnt            saturating count of preempted scanout reads
module vmem_arbiter #(
   parameter int AW = 19,
   parameter int DW = 24,
   parameter int MAX_WAIT = 64,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          vga_rd_req,
   input  logic [AW-1:0] vga_rd_addr,
   output logic [DW-1:0] vga_rd_data,
   output logic          vga_rd_valid,
   output logic          vga_underrun,
   input  logic          w0_valid,
   output logic          w0_ready,
   input  logic [AW-1:0] w0_addr,
   input  logic [DW-1:0] w0_data,
   input  logic          w1_valid,
   output logic          w1_ready,
   input  logic [AW-1:0] w1_addr,
   input  logic [DW-1:0] w1_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [CW-1:0] preempt_cnt
);
   localparam logic [7:0] MW = 8'(MAX_WAIT);
   logic [7:0] wait0, wait1;
   logic ptr, rd_p, pre_p, pre0, pre1, g0, g1, rd_go, preempt;
   // a starved writer outranks scanout; ptr = 0 favours writer 0 on ties
   always_comb begin
      pre0 = w0_valid && wait0 == MW;
      pre1 = w1_valid && wait1 == MW;
      g0 = 1'b0;
      g1 = 1'b0;
      rd_go = 1'b0;
      if (pre0 || pre1) begin
         g0 = pre0 && (!pre1 || !ptr);
         g1 = !g0;
      end else if (vga_rd_req) begin
         rd_go = 1'b1;
      end else if (w0_valid || w1_valid) begin
         g0 = w0_valid && (!w1_valid || !ptr);
         g1 = !g0;
      end
   end
   // a starved writer only counts as stealing a slot when scanout actually wanted it
   assign preempt   = (pre0 || pre1) && vga_rd_req;
   assign w0_ready  = resetn && g0;
   assign w1_ready  = resetn && g1;
   assign mem_en    = resetn && (g0 || g1 || rd_go);
   assign mem_we    = resetn && (g0 || g1);
   assign mem_addr  = g0 ? w0_addr : g1 ? w1_addr : vga_rd_addr;
   assign mem_wdata = g1 ? w1_data : w0_data;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wait0        <= '0;
         wait1        <= '0;
         ptr          <= 1'b0;
         rd_p         <= 1'b0;
         pre_p        <= 1'b0;
         vga_rd_data  <= '0;
         vga_rd_valid <= 1'b0;
         vga_underrun <= 1'b0;
         preempt_cnt  <= '0;
      end else begin
         wait0        <= (!w0_valid || g0) ? 8'd0 : (wait0 == MW ? wait0 : wait0 + 8'd1);
         wait1        <= (!w1_valid || g1) ? 8'd0 : (wait1 == MW ? wait1 : wait1 + 8'd1);
         ptr          <= g0 ? 1'b1 : g1 ? 1'b0 : ptr;
         rd_p         <= rd_go;
         pre_p        <= preempt;
         vga_rd_valid <= rd_p || pre_p;
         vga_underrun <= pre_p;
         if (rd_p) vga_rd_data <= mem_rdata;
         if (pre_p && preempt_cnt != {CW{1'b1}}) preempt_cnt <= preempt_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: randomized and directed bench for vmem_arbiter against a queue-based model
module tb_vmem_arbiter;
   localparam int AW = 19;
   localparam int DW = 24;
   localparam int MW = 4;
   localparam int CW = 3;
   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          vga_rd_req = 1'b0;
   logic [AW-1:0] vga_rd_addr = '0;
   logic [DW-1:0] vga_rd_data;
   logic          vga_rd_valid, vga_underrun;
   logic          w0_valid = 1'b0, w1_valid = 1'b0;
   logic          w0_ready, w1_ready;
   logic [AW-1:0] w0_addr = '0, w1_addr = '0;
   logic [DW-1:0] w0_data = '0, w1_data = '0;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [CW-1:0] preempt_cnt;

   vmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .CW(CW)) dut (
      .clk(clk), .resetn(resetn),
      .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr), .vga_rd_data(vga_rd_data),
      .vga_rd_valid(vga_rd_valid), .vga_underrun(vga_underrun),
      .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
      .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .preempt_cnt(preempt_cnt)
   );

   always #5 clk = ~clk;

   // storage array seen by the DUT; unwritten locations read as zero
   logic [DW-1:0] mem [logic [AW-1:0]];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         else mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : '0;
      end
   end

   typedef struct {
      int            kind;
      logic [DW-1:0] d;
   } ent_t;

   // reference model: kind 0 = no request, 1 = served read, 2 = preempted read
   ent_t          q[$];
   logic [DW-1:0] sh [logic [AW-1:0]];
   int            wt[2];
   int            ptr, cnt;
   logic [DW-1:0] vdata;
   logic          hold[2];
   logic [AW-1:0] wa[2];
   logic [DW-1:0] wd[2];
   logic          wv[2];
   logic          fix0 = 1'b0;
   logic          nrst = 1'b0;
   int            checks = 0, errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ent_t e;
      e.kind = 0;
      e.d = '0;
      q.delete();
      q.push_back(e);
      q.push_back(e);
      for (int i = 0; i < 2; i++) begin
         wt[i] = 0;
         hold[i] = 1'b0;
      end
      ptr = 0;
      cnt = 0;
      vdata = '0;
   endtask

   task automatic step(input logic req, input logic [AW-1:0] ra, input logic v0, input logic v1);
      int   win;
      logic pre[2];
      ent_t e, h;
      @(posedge clk);
      #1;
      resetn = nrst;
      for (int i = 0; i < 2; i++) begin
         if (!hold[i] && !(i == 0 && fix0)) begin
            wa[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            wd[i] = DW'($urandom);
         end
      end
      fix0 = 1'b0;
      wv[0] = v0;
      wv[1] = v1;
      vga_rd_req = req;
      vga_rd_addr = ra;
      w0_valid = wv[0];
      w0_addr = wa[0];
      w0_data = wd[0];
      w1_valid = wv[1];
      w1_addr = wa[1];
      w1_data = wd[1];
      @(negedge clk);
      if (!nrst) begin
         model_reset();
         check("rst_mem_en", 32'(mem_en), 32'(0));
         check("rst_w0_ready", 32'(w0_ready), 32'(0));
         check("rst_w1_ready", 32'(w1_ready), 32'(0));
         check("rst_rd_valid", 32'(vga_rd_valid), 32'(0));
         check("rst_underrun", 32'(vga_underrun), 32'(0));
         check("rst_rd_data", 32'(vga_rd_data), 32'(0));
         check("rst_pcnt", 32'(preempt_cnt), 32'(0));
         return;
      end
      h = q.pop_front();
      if (h.kind == 1) vdata = h.d;
      if (h.kind == 2 && cnt < (1 << CW) - 1) cnt++;
      check("rd_valid", 32'(vga_rd_valid), 32'(h.kind != 0));
      check("underrun", 32'(vga_underrun), 32'(h.kind == 2));
      check("rd_data", 32'(vga_rd_data), 32'(vdata));
      check("pcnt", 32'(preempt_cnt), 32'(cnt));
      for (int i = 0; i < 2; i++) pre[i] = wv[i] && wt[i] == MW;
      win = -1;
      if (pre[0] || pre[1]) win = (pre[0] && pre[1]) ? ptr : (pre[1] ? 1 : 0);
      else if (!req && (wv[0] || wv[1])) win = (wv[0] && wv[1]) ? ptr : (wv[1] ? 1 : 0);
      e.kind = 0;
      e.d = '0;
      if (req && win < 0) begin
         e.kind = 1;
         e.d = sh.exists(ra) ? sh[ra] : '0;
      end else if (req) begin
         e.kind = 2;
      end
      q.push_back(e);
      check("mem_en", 32'(mem_en), 32'(req || win >= 0));
      check("w0_ready", 32'(w0_ready), 32'(win == 0));
      check("w1_ready", 32'(w1_ready), 32'(win == 1));
      if (win >= 0) begin
         check("mem_we_wr", 32'(mem_we), 32'(1));
         check("mem_addr_wr", 32'(mem_addr), 32'(wa[win]));
         check("mem_wdata", 32'(mem_wdata), 32'(wd[win]));
         sh[wa[win]] = wd[win];
         ptr = 1 - win;
      end else if (req) begin
         check("mem_we_rd", 32'(mem_we), 32'(0));
         check("mem_addr_rd", 32'(mem_addr), 32'(ra));
      end
      for (int i = 0; i < 2; i++) begin
         hold[i] = wv[i] && win != i;
         wt[i] = (!wv[i] || win == i) ? 0 : (wt[i] < MW ? wt[i] + 1 : MW);
      end
   endtask

   task automatic rstep();
      logic          r;
      logic [AW-1:0] a;
      r = $urandom_range(0, 9) != 0;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      step(r, a, hold[0] || ($urandom_range(0, 2) == 0), hold[1] || ($urandom_range(0, 2) == 0));
   endtask

   initial begin
      model_reset();
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b1, '0, 1'b1, 1'b1);
      nrst = 1'b1;
      // idle, then a write of 0xABCDEF to 0x5 and a scanout read of it
      step(1'b0, '0, 1'b0, 1'b0);
      check("idle_en", 32'(mem_en), 32'(0));
      check("idle_data", 32'(vga_rd_data), 32'(0));
      wa[0] = AW'(5);
      wd[0] = 24'hABCDEF;
      fix0 = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, AW'(5), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      check("rd1_valid_early", 32'(vga_rd_valid), 32'(0));
      step(1'b0, '0, 1'b0, 1'b0);
      check("rd1_valid", 32'(vga_rd_valid), 32'(1));
      check("rd1_data", 32'(vga_rd_data), 32'hABCDEF);
      // both writers valid, no scanout: grants alternate starting at writer 1 (ptr moved after w0)
      step(1'b0, '0, 1'b1, 1'b1);
      check("rr1_w1", 32'(w1_ready), 32'(1));
      step(1'b0, '0, 1'b1, 1'b1);
      check("rr2_w0", 32'(w0_ready), 32'(1));
      step(1'b0, '0, 1'b1, 1'b1);
      check("rr3_w1", 32'(w1_ready), 32'(1));
      step(1'b0, '0, 1'b1, 1'b1);
      check("rr4_w0", 32'(w0_ready), 32'(1));
      step(1'b0, '0, 1'b0, 1'b0);
      // writer 0 starved by continuous scanout
      for (int i = 0; i < 4; i++) begin
         step(1'b1, AW'(5), 1'b1, 1'b0);
         check("starve_w0_wait", 32'(w0_ready), 32'(0));
      end
      step(1'b1, AW'(5), 1'b1, 1'b0);
      check("starve_w0_grant", 32'(w0_ready), 32'(1));
      step(1'b1, AW'(5), 1'b0, 1'b0);
      check("starve_no_underrun", 32'(vga_underrun), 32'(0));
      step(1'b1, AW'(5), 1'b0, 1'b0);
      check("starve_underrun", 32'(vga_underrun), 32'(1));
      check("starve_pcnt", 32'(preempt_cnt), 32'(1));
      // both starved: pointer favours writer 1, writer 0 takes the next slot
      for (int i = 0; i < 4; i++) step(1'b1, AW'(5), 1'b1, 1'b1);
      step(1'b1, AW'(5), 1'b1, 1'b1);
      check("both_first_w1", 32'(w1_ready), 32'(1));
      check("both_first_w0", 32'(w0_ready), 32'(0));
      step(1'b1, AW'(5), 1'b1, 1'b0);
      check("both_second_w0", 32'(w0_ready), 32'(1));
      step(1'b1, AW'(5), 1'b0, 1'b0);
      step(1'b1, AW'(5), 1'b0, 1'b0);
      check("both_pcnt", 32'(preempt_cnt), 32'(3));
      // write then read the same address on the next cycle
      wa[0] = AW'(20'h1F3A0);
      wd[0] = 24'h123456;
      fix0 = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0);
      check("raw_wr", 32'(w0_ready), 32'(1));
      step(1'b1, AW'(20'h1F3A0), 1'b0, 1'b0);
      step(1'b1, AW'(20'h1F3A0), 1'b0, 1'b0);
      step(1'b1, AW'(20'h1F3A0), 1'b0, 1'b0);
      check("raw_data", 32'(vga_rd_data), 32'h123456);
      // reset asserted mid-cycle while a read is in flight
      step(1'b1, AW'(20'h1F3A0), 1'b0, 1'b0);
      #2;
      resetn = 1'b0;
      nrst = 1'b0;
      #1;
      check("async_valid", 32'(vga_rd_valid), 32'(0));
      check("async_data", 32'(vga_rd_data), 32'(0));
      check("async_en", 32'(mem_en), 32'(0));
      check("async_pcnt", 32'(preempt_cnt), 32'(0));
      for (int i = 0; i < 3; i++) step(1'b1, AW'(20'h1F3A0), 1'b1, 1'b0);
      nrst = 1'b1;
      step(1'b1, AW'(20'h1F3A0), 1'b0, 1'b0);
      check("post_rst_v1", 32'(vga_rd_valid), 32'(0));
      step(1'b1, AW'(20'h1F3A0), 1'b0, 1'b0);
      check("post_rst_v2", 32'(vga_rd_valid), 32'(0));
      step(1'b1, AW'(20'h1F3A0), 1'b0, 1'b0);
      check("post_rst_v3", 32'(vga_rd_valid), 32'(1));
      check("post_rst_data", 32'(vga_rd_data), 32'h123456);
      for (int i = 0; i < 4000; i++) rstep();
      check("pcnt_saturated", 32'(preempt_cnt), 32'(7));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Shares the single-port video memory between three requesters:
  - VGA scanout reads, issued by vga_ctrl through its h_addr/v_addr port.
  - Two pixel writers: port 0 is the keyboard-driven drawer, port 1 is the UART image loader.
- Scanout has priority. Writers are served round-robin in the remaining cycles.
- A per-writer starvation watchdog lets a waiting writer steal one scanout slot. The stolen slot is reported as an underrun.
- Sits between vga_ctrl/writers and the vmem storage array.

Parameters:
AW, 19, memory address width ({h_addr[9:0], v_addr[8:0]})
DW, 24, pixel width (RGB888)
MAX_WAIT, 64, cycles a writer may wait with valid high before it preempts scanout; legal range 1..255
CW, 16, width of the saturating preempt counter

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
vga_rd_req  in  1  scanout read request for this cycle (tie to VGA valid)
vga_rd_addr  in  AW  scanout pixel address
vga_rd_data  out  DW  registered pixel data returned to vga_ctrl
vga_rd_valid  out  1  vga_rd_data corresponds to the request 2 cycles earlier
vga_underrun  out  1  one-cycle pulse: the returned data is stale because its read was preempted
w0_valid  in  1  writer 0 request
w0_ready  out  1  writer 0 accepted this cycle
w0_addr  in  AW  writer 0 address
w0_data  in  DW  writer 0 data
w1_valid, w1_ready, w1_addr, w1_data  as writer 0, for writer 1
mem_en  out  1  memory access this cycle
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  read data, valid the cycle after a read access
preempt_cnt  out  CW  saturating count of preempted scanout reads

Behaviour:
- Reset (resetn low, asynchronous) clears:
  - vga_rd_data to 0; vga_rd_valid and vga_underrun to 0.
  - preempt_cnt to 0; round-robin pointer to writer 0; both wait counters to 0.
  - The read-pipeline flags.
  - mem_en is 0 while resetn is low.
- Resolution order each cycle (combinational grant, one grant max):
  1. Writer preempt: any writer with wait counter == MAX_WAIT and valid high. If both qualify, the round-robin pointer picks.
  2. Otherwise, scanout read, if vga_rd_req.
  3. Otherwise, writer: if only one is valid, it is granted. If both are valid, the writer the pointer selects is granted.
  4. Otherwise, idle (mem_en = 0).
- Write grant:
  - wN_ready = 1, mem_en = 1, mem_we = 1, mem_addr/mem_wdata = wN_addr/wN_data, in the same cycle.
  - Handshake completes on wN_valid & wN_ready.
  - Writers must hold addr/data stable while valid and not ready.
  - ready is never asserted without valid.
- Round-robin pointer: after any writer grant, the pointer moves to the other writer. It is unchanged otherwise.
- Wait counters:
  - Per writer, 8 bit.
  - Increment when valid & ~ready, saturating at MAX_WAIT.
  - Clear on grant or when valid is low.
- Scanout read pipeline:
  - Request in cycle N.
  - If served: mem read in N, mem_rdata sampled in N+1, vga_rd_data updated at end of N+1. It is visible with vga_rd_valid = 1 in N+2 (latency 2).
  - If vga_rd_req in N was preempted: in N+2, vga_rd_valid = 1 and vga_rd_data holds its previous value. vga_underrun = 1 for that cycle.
  - preempt_cnt increments, saturating at 2^CW−1.
  - vga_rd_valid = 0 in N+2 when vga_rd_req was 0 in N.
- Writes never block scanout except through the preempt path. Back-to-back requests give a throughput of one access per cycle.
- Read-after-write to the same address: a write granted in cycle N is visible to a scanout read in N+1 or later. No forwarding is done.
- Simultaneous preempt and vga_rd_req=0: counts as a normal writer grant, not a preemption. No underrun.
- Reset mid-operation:
  - Pending reads are discarded. vga_rd_valid is 0 for 2 cycles after resetn rises, even when vga_rd_req stays high.
  - An in-flight writer handshake is not accepted while resetn is low.

Test Plan:
- Idle after reset → mem_en=0, all readys 0, vga_rd_data=0, preempt_cnt=0. Then vga_rd_req=1 at addr 0x00005 with mem holding 0xABCDEF → vga_rd_data=0xABCDEF with vga_rd_valid=1, exactly 2 cycles later.
- vga_rd_req=0, w0 and w1 both valid for 4 cycles → grants alternate w0,w1,w0,w1. mem_we=1 on each, with the matching addr/data.
- vga_rd_req=1 continuously, w0_valid=1 held (MAX_WAIT=4) → w0_ready=0 for 4 cycles, then 1 in cycle 5. vga_underrun pulses 2 cycles later with vga_rd_data unchanged. preempt_cnt=1. Wait counter cleared.
- Both writers starved past MAX_WAIT under continuous scanout → both get preempt grants in pointer order, on consecutive preempt slots. preempt_cnt=2.
- Write 0x123456 to addr 0x1F3A0 in cycle N, scanout read of the same addr in N+1 → vga_rd_data=0x123456 in N+3.
- Assert resetn=0 one cycle after a scanout request, release after 3 cycles → outputs zero asynchronously. vga_rd_valid stays 0 for 2 cycles after release despite vga_rd_req=1.
